// File: rtl/dr_pkg.sv
// Shared definitions for the dual-rail transmit front end: FSM encoding and
// synchronizer settings.
package dr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_SPACER = 2'd2
  } dr_state_e;

  localparam int unsigned SYNC_STAGES  = 2;
  localparam logic        SYNC_RST_VAL = 1'b1;

endpackage : dr_pkg

// File: rtl/dr_tx_ctrl_if.sv
// Source valid/ready bus plus transmitter data/in_rdy/ack lines of dr_tx_ctrl.
// master = upstream source and receiver side, slave = dr_tx_ctrl.
interface dr_tx_ctrl_if #(
  parameter int unsigned N = 16
) ();

  logic [N-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] tx_data;
  logic         tx_rdy;
  logic         ack_async;

  modport master (
    output s_data, s_valid, ack_async,
    input  s_ready, tx_data, tx_rdy
  );

  modport slave (
    input  s_data, s_valid, ack_async,
    output s_ready, tx_data, tx_rdy
  );

endinterface : dr_tx_ctrl_if

// File: rtl/dr_sync2.sv
// Generic multi-flop synchronizer with synchronous active-low reset and a
// configurable reset value.
module dr_sync2
  import dr_pkg::*;
#(
  parameter int unsigned STAGES  = SYNC_STAGES,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : dr_sync2

// File: rtl/dr_tx_ctrl.sv
// Synchronous front end for the dual-rail transmitter: FIFO plus 4-phase RZ
// handshake sequencer. Optional ack timeout flag via DR_TX_CTRL_TIMEOUT_EN.
module dr_tx_ctrl
  import dr_pkg::*;
#(
  parameter int unsigned N           = 16,
  parameter int unsigned DEPTH       = 4
`ifdef DR_TX_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dr_tx_ctrl_if.slave            bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef DR_TX_CTRL_TIMEOUT_EN
  ,
  output logic                   err_timeout
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic             ack_s;
  logic [N-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             full_c, empty_c;
  logic             push_c, pop_c;
  logic             adv_c;
  dr_state_e        state_q;
  logic             tx_rdy_q;
  logic [N-1:0]     tx_data_q;

  dr_sync2 #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SYNC_RST_VAL)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.ack_async),
    .q_o   (ack_s)
  );

  // Circular buffer: extra pointer MSB distinguishes full from empty.
  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_c  = bus.s_valid & ~full_c;
  assign pop_c   = (state_q == ST_IDLE) & ~empty_c;

  always_comb begin
    wptr_d = wptr_q + PW'(push_c);
    rptr_d = rptr_q + PW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wptr_q[AW-1:0]] <= bus.s_data;
    end
  end

  // FSM leaves its current state when this is high.
  always_comb begin
    adv_c = 1'b0;
    case (state_q)
      ST_IDLE:   adv_c = ~empty_c;
      ST_DATA:   adv_c = ack_s;
      ST_SPACER: adv_c = ~ack_s;
      default:   adv_c = 1'b1;
    endcase
  end

  // Resetting into SPACER forces a wait for ack low before the first word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_SPACER;
      tx_rdy_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (adv_c) begin
            tx_data_q <= mem_q[rptr_q[AW-1:0]];
            tx_rdy_q  <= 1'b1;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (adv_c) begin
            tx_rdy_q <= 1'b0;
            state_q  <= ST_SPACER;
          end
        end
        ST_SPACER: begin
          if (adv_c) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_rdy_q <= 1'b0;
          state_q  <= ST_SPACER;
        end
      endcase
    end
  end

`ifdef DR_TX_CTRL_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q;

  // Saturating dwell counter, cleared whenever the FSM changes state.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (adv_c) begin
      to_cnt_d = '0;
    end else if ((state_q != ST_IDLE) && (to_cnt_q != TW'(TIMEOUT_CYC - 1))) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_q;
`endif

  assign bus.s_ready = ~full_c;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_rdy  = tx_rdy_q;
  assign busy        = ~empty_c | (state_q != ST_IDLE);
  assign fifo_count  = wptr_q - rptr_q;

endmodule : dr_tx_ctrl

// File: tb/tb_dr_tx_ctrl.sv
// Bench for dr_tx_ctrl: directed handshake/latency/reset steps plus a random
// traffic phase, checked against a word-queue model and a delayed-ack receiver.
module tb_dr_tx_ctrl;

  localparam int unsigned N = 16;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic [$clog2(D):0] fifo_count;
`ifdef DR_TX_CTRL_TIMEOUT_EN
  logic err_timeout;
`endif

  dr_tx_ctrl_if #(.N(N)) bus ();

  dr_tx_ctrl #(
    .N           (N),
    .DEPTH       (D)
`ifdef DR_TX_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (8)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .busy       (busy),
    .fifo_count (fifo_count)
`ifdef DR_TX_CTRL_TIMEOUT_EN
    ,
    .err_timeout(err_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Receiver: ack follows tx_rdy after rx_dly clock edges, or manual control.
  logic [7:0] rx_pipe = '0;
  int         rx_dly  = 2;
  logic       rx_auto = 1'b0;
  logic       ack_man = 1'b0;
  logic       ack_model;

  always @(posedge clk) rx_pipe <= {rx_pipe[6:0], bus.tx_rdy};
  assign ack_model     = rx_pipe[3'(rx_dly - 1)];
  assign bus.ack_async = rx_auto ? ack_model : ack_man;

  // Model: words accepted but not yet issued, in order.
  logic [N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: issue order, data hold while tx_rdy, occupancy.
  logic         prev_rdy = 1'b0;
  logic [N-1:0] held     = '0;
  always @(posedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      if (bus.tx_rdy && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_issue", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("issue_order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
        held = bus.tx_data;
      end else if (bus.tx_rdy && prev_rdy) begin
        chk("data_hold", 32'(bus.tx_data), 32'(held));
      end
      chk("occupancy", 32'(fifo_count), 32'(exp_q.size()));
    end
    prev_rdy = bus.tx_rdy;
  end

  task automatic push_word(input logic [N-1:0] w);
    chk("push_s_ready", 32'(bus.s_ready), 32'(exp_q.size() < D));
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    if (bus.s_ready) exp_q.push_back(w);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Edges until tx_rdy reaches want (at least one).
  task automatic wait_rdy(input logic want, input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_rdy !== want && n < 60);
    chk(tag, 32'(bus.tx_rdy), 32'(want));
  endtask

  task automatic wait_ack(input logic want, input string tag);
    int n = 0;
    while (bus.ack_async !== want && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.ack_async), 32'(want));
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int g;
    int sent;
    logic saw_full;
    logic [N-1:0] w;

    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // 1: reset values, then SPACER -> IDLE once ack is seen low.
    repeat (3) @(negedge clk);
    chk("rst_tx_rdy", 32'(bus.tx_rdy), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy_spacer", 32'(busy), 32'd1);
`ifdef DR_TX_CTRL_TIMEOUT_EN
    chk("rst_err", 32'(err_timeout), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_busy_2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("rel_busy_3", 32'(busy), 32'd0);
    chk("rel_tx_rdy", 32'(bus.tx_rdy), 32'd0);
    chk("rel_s_ready", 32'(bus.s_ready), 32'd1);

    // 2: single word, receiver acks 2 cycles after tx_rdy.
    rx_dly  = 2;
    rx_auto = 1'b1;
    push_word(16'hA5C3);
    chk("nobypass_rdy", 32'(bus.tx_rdy), 32'd0);
    chk("nobypass_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("issue_rdy", 32'(bus.tx_rdy), 32'd1);
    chk("issue_data", 32'(bus.tx_data), 32'h0000A5C3);
    push_word(16'(($urandom)));
    wait_ack(1'b1, "ack_rise");
    wait_rdy(1'b0, "rdy_fall", n);
    chk("ack_to_fall_lat", 32'(n), 32'd3);
    wait_ack(1'b0, "ack_fall");
    wait_rdy(1'b1, "rdy_rise2", n);
    chk("ack_low_to_next_lat", 32'(n), 32'd4);
    drain("drain2");

    // 3: six words back-to-back against a 4-deep FIFO.
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      g = 0;
      while (!bus.s_ready && g < 100) begin
        if (exp_q.size() == D) saw_full = 1'b1;
        chk("full_s_ready", 32'(bus.s_ready), 32'(exp_q.size() < D));
        @(negedge clk);
        g++;
      end
      push_word(16'($urandom));
    end
    chk("full_seen", 32'(saw_full), 32'd1);
    drain("drain3");
    chk("drain3_s_ready", 32'(bus.s_ready), 32'd1);

    // 4: manual ack; push into empty, then push+pop at count 2.
    ack_man = 1'b0;
    rx_auto = 1'b0;
    @(negedge clk);
    push_word(16'h1111);
    chk("s4_nobypass_rdy", 32'(bus.tx_rdy), 32'd0);
    chk("s4_nobypass_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("s4_pop_rdy", 32'(bus.tx_rdy), 32'd1);
    chk("s4_pop_count", 32'(fifo_count), 32'd0);
    push_word(16'h2222);
    push_word(16'h3333);
    @(negedge clk);
`ifdef DR_TX_CTRL_TIMEOUT_EN
    chk("to_early", 32'(err_timeout), 32'd0);
`endif
    repeat (6) @(negedge clk);
`ifdef DR_TX_CTRL_TIMEOUT_EN
    chk("to_set", 32'(err_timeout), 32'd1);
`endif
    chk("s4_count2", 32'(fifo_count), 32'd2);
    chk("s4_hold_rdy", 32'(bus.tx_rdy), 32'd1);
    ack_man = 1'b1;
    wait_rdy(1'b0, "s4_rdy_fall", n);
    chk("s4_fall_lat", 32'(n), 32'd3);
    ack_man = 1'b0;
    repeat (3) @(negedge clk);
    chk("s4_pre_pp_rdy", 32'(bus.tx_rdy), 32'd0);
    chk("s4_pre_pp_count", 32'(fifo_count), 32'd2);
    push_word(16'h4444);
    chk("s4_pp_count", 32'(fifo_count), 32'd2);
    chk("s4_pp_rdy", 32'(bus.tx_rdy), 32'd1);
    chk("s4_pp_data", 32'(bus.tx_data), 32'h00002222);
`ifdef DR_TX_CTRL_TIMEOUT_EN
    chk("to_sticky", 32'(err_timeout), 32'd1);
`endif
    rx_auto = 1'b1;
    drain("drain4");
    rx_auto = 1'b0;

    // 5: ack held high across reset, then reset during DATA.
    ack_man = 1'b1;
    rst_n   = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("s5_rst_rdy", 32'(bus.tx_rdy), 32'd0);
`ifdef DR_TX_CTRL_TIMEOUT_EN
    chk("to_cleared", 32'(err_timeout), 32'd0);
`endif
    rst_n = 1'b1;
    push_word(16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      chk("s5_ack_hi_no_rdy", 32'(bus.tx_rdy), 32'd0);
      @(negedge clk);
    end
    chk("s5_ack_hi_count", 32'(fifo_count), 32'd1);
    ack_man = 1'b0;
    wait_rdy(1'b1, "s5_rdy_rise", n);
    chk("s5_ack_low_lat", 32'(n), 32'd4);
    chk("s5_data", 32'(bus.tx_data), 32'h0000BEEF);
    push_word(16'hCAFE);
    chk("s5_count_pre", 32'(fifo_count), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("s5_midrst_rdy", 32'(bus.tx_rdy), 32'd0);
    chk("s5_midrst_count", 32'(fifo_count), 32'd0);
    chk("s5_midrst_data", 32'(bus.tx_data), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("s5_idle_busy", 32'(busy), 32'd0);

    // 6: random traffic with a random receiver delay.
    rx_dly  = int'($urandom_range(1, 3));
    rx_auto = 1'b1;
    sent = 0;
    g = 0;
    while (sent < 24 && g < 2000) begin
      if (bus.s_ready && ($urandom_range(0, 1) == 1)) begin
        push_word(16'($urandom));
        sent++;
      end else begin
        chk("rnd_s_ready", 32'(bus.s_ready), 32'(exp_q.size() < D));
        @(negedge clk);
      end
      g++;
    end
    chk("rnd_sent", 32'(sent), 32'd24);
    drain("drain6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dr_tx_ctrl
